// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency meter: the measurement FSM state type
// and the default gate length / result width. The defaults match
// clock_divider, so a speed value and a measured frequency use the same
// 20-bit scale.
// ---------------------------------------------------------------------------
package freq_meter_pkg;

  // Board clock in Hz; also the gate window length in clock cycles (1 s).
  localparam int unsigned DEFAULT_BASE_SPEED = 50_000_000;

  // Result width, the same as the clock_divider speed input.
  localparam int unsigned DEFAULT_FREQ_W = 20;

  // IDLE holds both counters at zero; MEASURE runs the gate window.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/freq_meter_if.sv
// ---------------------------------------------------------------------------
// freq_meter_if
// Groups the measurement control, the signal under test and the result of
// the frequency meter.
//   en    : measurement enable (low holds the meter idle)
//   sig   : square wave under test, asynchronous to the system clock
//   freq  : rising-edge count of the last completed window, saturated
//   valid : one-cycle pulse when freq/ovf update
//   ovf   : last completed window held more edges than freq can show
// master = the side that drives en/sig, slave = the meter itself.
// ---------------------------------------------------------------------------
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned FREQ_W = DEFAULT_FREQ_W
);

  logic              en;
  logic              sig;
  logic [FREQ_W-1:0] freq;
  logic              valid;
  logic              ovf;

  modport master (
    output en,
    output sig,
    input  freq,
    input  valid,
    input  ovf
  );

  modport slave (
    input  en,
    input  sig,
    output freq,
    output valid,
    output ovf
  );

endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous input into the clk domain with a 2-flop
// synchronizer and produces a registered one-cycle pulse for every rising
// edge of the synchronized level. Also usable for push buttons.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   d    : asynchronous input level
//   rise : one-cycle pulse, two cycles after d is first sampled high
// ---------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic syncPrev_q;
  logic rise_q;

  // Two synchronizer stages (meta_q may go metastable; sync_q is safe to
  // use), then a copy of the previous synchronized level so a 0->1 step can
  // be seen. The pulse is registered so it is glitch-free for the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      syncPrev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      meta_q     <= d;
      sync_q     <= meta_q;
      syncPrev_q <= sync_q;
      rise_q     <= sync_q & ~syncPrev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
// Counts rising edges of bus.sig over gate windows of exactly BASE_SPEED
// clock cycles and reports the count in Hz. Windows run back-to-back while
// bus.en is high; dropping en discards the window in progress.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : freq_meter_if slave (en, sig in; freq, valid, ovf out)
// BASE_SPEED must be at least 2.
// ---------------------------------------------------------------------------
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned BASE_SPEED = DEFAULT_BASE_SPEED,
  parameter int unsigned FREQ_W     = DEFAULT_FREQ_W
) (
  input  logic         clk,
  input  logic         rst,
  freq_meter_if.slave  bus
);

  localparam int unsigned GATE_W = $clog2(BASE_SPEED);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(BASE_SPEED - 1);

  logic              rise;
  state_e            state_q, state_d;
  logic [GATE_W-1:0] gateCnt_q, gateCnt_d;
  logic [FREQ_W:0]   edgeCnt_q, edgeCnt_d;
  logic [FREQ_W:0]   edgeTotal;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  sync_edge_detect uSync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sig),
    .rise (rise)
  );

  // Edge count including this cycle's pulse. The extra top bit is sticky:
  // once the count passes 2^FREQ_W-1 it stops moving, so it cannot wrap
  // back into range however fast sig runs.
  assign edgeTotal = edgeCnt_q[FREQ_W] ? edgeCnt_q
                                       : edgeCnt_q + (FREQ_W+1)'(rise);

  // Next-state logic. The first cycle with en high is already gate count 0
  // and its edge pulse counts. On the last gate cycle the result is taken
  // from edgeTotal, so a pulse landing there belongs to the ending window,
  // and the counter restarts at 0 for the next one.
  always_comb begin
    state_d   = state_q;
    gateCnt_d = gateCnt_q;
    edgeCnt_d = edgeCnt_q;
    freq_d    = freq_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gateCnt_d = '0;
        edgeCnt_d = '0;
        if (bus.en) begin
          state_d   = MEASURE;
          gateCnt_d = GATE_W'(1);
          edgeCnt_d = edgeTotal;
        end
      end
      MEASURE: begin
        if (!bus.en) begin
          state_d   = IDLE;
          gateCnt_d = '0;
          edgeCnt_d = '0;
        end else if (gateCnt_q == GATE_LAST) begin
          gateCnt_d = '0;
          edgeCnt_d = '0;
          ovf_d     = edgeTotal[FREQ_W];
          freq_d    = edgeTotal[FREQ_W] ? '1 : edgeTotal[FREQ_W-1:0];
          valid_d   = 1'b1;
        end else begin
          gateCnt_d = gateCnt_q + GATE_W'(1);
          edgeCnt_d = edgeTotal;
        end
      end
      default: begin
        state_d   = IDLE;
        gateCnt_d = '0;
        edgeCnt_d = '0;
      end
    endcase
  end

  // State and result registers. Reset aborts any window without a valid
  // pulse and clears the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gateCnt_q <= '0;
      edgeCnt_q <= '0;
      freq_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gateCnt_q <= gateCnt_d;
      edgeCnt_q <= edgeCnt_d;
      freq_q    <= freq_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.freq  = freq_q;
  assign bus.ovf   = ovf_q;
  assign bus.valid = valid_q;

endmodule
